// File: rtl/param_stack_if.sv
// Handshake bundle for param_stack: request strobes in, stack view out.
// hwm exists only when STACK_HWM_EN is defined.
interface param_stack_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             push_en;
  logic             pop_en;
  logic [WIDTH-1:0] push_data;
  logic             err_clr;
  logic [WIDTH-1:0] top;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;
`ifdef STACK_HWM_EN
  logic [CW-1:0]    hwm;
`endif

`ifdef STACK_HWM_EN
  modport master (
    output push_en, pop_en, push_data, err_clr,
    input  top, count, full, empty,
    input  overflow, underflow, hwm
  );
  modport slave (
    input  push_en, pop_en, push_data, err_clr,
    output top, count, full, empty,
    output overflow, underflow, hwm
  );
`else
  modport master (
    output push_en, pop_en, push_data, err_clr,
    input  top, count, full, empty,
    input  overflow, underflow
  );
  modport slave (
    input  push_en, pop_en, push_data, err_clr,
    output top, count, full, empty,
    output overflow, underflow
  );
`endif
endinterface

// File: rtl/param_stack.sv
// Parametrised LIFO with replace-top, sticky error flags and zero-latency top.
// Optional high-water mark enabled by defining STACK_HWM_EN.
module param_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic      clk,
  input  logic      clr_n,
  param_stack_if.slave stk
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_PUSH,
    OP_POP,
    OP_REP,
    OP_OVF,
    OP_UDF
  } op_e;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             udf_q;
  logic             udf_d;
  logic             full;
  logic             empty;
  logic             we;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    wr_idx;
  op_e              op;

  assign full    = (cnt_q == FULL_C);
  assign empty   = (cnt_q == '0);
  assign top_idx = AW'(cnt_q - ONE_C);

  always_comb begin
    op = OP_HOLD;
    unique case (1'b1)
      stk.push_en & ~stk.pop_en & ~full:  op = OP_PUSH;
      stk.push_en & ~stk.pop_en & full:   op = OP_OVF;
      ~stk.push_en & stk.pop_en & ~empty: op = OP_POP;
      ~stk.push_en & stk.pop_en & empty:  op = OP_UDF;
      stk.push_en & stk.pop_en & ~empty:  op = OP_REP;
      // push+pop on empty degenerates to push
      stk.push_en & stk.pop_en & empty:   op = OP_PUSH;
      default:                            op = OP_HOLD;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    we     = 1'b0;
    wr_idx = AW'(cnt_q);
    unique case (op)
      OP_PUSH: begin
        cnt_d = cnt_q + ONE_C;
        we    = 1'b1;
      end
      OP_POP:  cnt_d = cnt_q - ONE_C;
      OP_REP: begin
        we     = 1'b1;
        wr_idx = top_idx;
      end
      default: cnt_d = cnt_q;
    endcase
  end

  assign ovf_d = (op == OP_OVF) | (ovf_q & ~stk.err_clr);
  assign udf_d = (op == OP_UDF) | (udf_q & ~stk.err_clr);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  // storage is never cleared; reset only blocks the write
  always_ff @(posedge clk) begin
    if (clr_n && we) begin
      mem[wr_idx] <= stk.push_data;
    end
  end

  assign stk.top       = empty ? '0 : mem[top_idx];
  assign stk.count     = cnt_q;
  assign stk.full      = full;
  assign stk.empty     = empty;
  assign stk.overflow  = ovf_q;
  assign stk.underflow = udf_q;

`ifdef STACK_HWM_EN
  logic [CW-1:0] hwm_q;
  logic [CW-1:0] hwm_d;

  always_comb begin
    hwm_d = hwm_q;
    if (stk.err_clr) begin
      hwm_d = cnt_d;
    end else if (cnt_d > hwm_q) begin
      hwm_d = cnt_d;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hwm_q <= '0;
    end else begin
      hwm_q <= hwm_d;
    end
  end

  assign stk.hwm = hwm_q;
`endif
endmodule

// File: tb/tb_param_stack.sv
// Randomised scoreboard bench for param_stack (WIDTH=8, DEPTH=5).
// Queue-based LIFO reference model; monitor compares after every edge.
module tb_param_stack;
  localparam int W  = 8;
  localparam int D  = 5;
  localparam int CW = $clog2(D + 1);

  typedef struct {
    int cnt;
    int top;
    int ovf;
    int udf;
    int hwm;
  } exp_t;

  logic clk = 1'b0;
  logic clr_n = 1'b0;

  param_stack_if #(.WIDTH(W), .DEPTH(D)) bus ();

  param_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .stk   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mstk[$];
  int m_ovf = 0;
  int m_udf = 0;
  int m_hwm = 0;
  exp_t exp_q[$];

  function automatic void chk(string n, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               n, act, act, req, req);
    end
  endfunction

  function automatic exp_t snap();
    exp_t e;
    e.cnt = mstk.size();
    e.top = (mstk.size() == 0) ? 0 : int'(mstk[$]);
    e.ovf = m_ovf;
    e.udf = m_udf;
    e.hwm = m_hwm;
    return e;
  endfunction

  function automatic void model_reset();
    mstk.delete();
    m_ovf = 0;
    m_udf = 0;
    m_hwm = 0;
  endfunction

  // LIFO rules expressed directly on a queue
  function automatic void model_step(bit p, bit q, logic [W-1:0] d, bit ec);
    int n;
    bit so;
    bit su;
    n  = mstk.size();
    so = 0;
    su = 0;
    if (p && q) begin
      if (n == 0) mstk.push_back(d);
      else mstk[n-1] = d;
    end else if (p) begin
      if (n == D) so = 1;
      else mstk.push_back(d);
    end else if (q) begin
      if (n == 0) su = 1;
      else void'(mstk.pop_back());
    end
    m_ovf = so ? 1 : (ec ? 0 : m_ovf);
    m_udf = su ? 1 : (ec ? 0 : m_udf);
    if (ec) m_hwm = mstk.size();
    else if (mstk.size() > m_hwm) m_hwm = mstk.size();
  endfunction

  task automatic cyc(bit p, bit q, logic [W-1:0] d, bit ec);
    @(negedge clk);
    bus.push_en   = p;
    bus.pop_en    = q;
    bus.push_data = d;
    bus.err_clr   = ec;
    model_step(p, q, d, ec);
    exp_q.push_back(snap());
  endtask

  task automatic idle_drain();
    int t;
    @(negedge clk);
    bus.push_en = 0;
    bus.pop_en  = 0;
    bus.err_clr = 0;
    t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic check_state(string tag);
    chk({tag, "_count"}, int'(bus.count), mstk.size());
    chk({tag, "_empty"}, int'(bus.empty), int'(mstk.size() == 0));
    chk({tag, "_full"}, int'(bus.full), int'(mstk.size() == D));
    chk({tag, "_top"}, int'(bus.top), snap().top);
    chk({tag, "_ovf"}, int'(bus.overflow), m_ovf);
    chk({tag, "_udf"}, int'(bus.underflow), m_udf);
`ifdef STACK_HWM_EN
    chk({tag, "_hwm"}, int'(bus.hwm), m_hwm);
`endif
  endtask

  // reset pulse placed strictly between two edges
  task automatic reset_pulse();
    idle_drain();
    #2;
    clr_n = 0;
    model_reset();
    #1;
    check_state("rst_async");
    #1;
    clr_n = 1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("mon_count", int'(bus.count), e.cnt);
        chk("mon_top", int'(bus.top), e.top);
        chk("mon_full", int'(bus.full), int'(e.cnt == D));
        chk("mon_empty", int'(bus.empty), int'(e.cnt == 0));
        chk("mon_ovf", int'(bus.overflow), e.ovf);
        chk("mon_udf", int'(bus.underflow), e.udf);
`ifdef STACK_HWM_EN
        chk("mon_hwm", int'(bus.hwm), e.hwm);
`endif
      end
    end
  end

  initial begin : stim
    logic [7:0] pat [6];
    pat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    bus.push_en   = 0;
    bus.pop_en    = 0;
    bus.push_data = '0;
    bus.err_clr   = 0;
    #1;
    check_state("rst_hold");
    repeat (2) @(negedge clk);
    clr_n = 1;

    // fill to DEPTH, overflow, clear
    for (int i = 0; i < 6; i++) cyc(1, 0, pat[i], 0);
    cyc(0, 0, 8'h00, 1);
    // drain, underflow, clear
    for (int i = 0; i < 6; i++) cyc(0, 1, 8'h00, 0);
    cyc(0, 0, 8'h00, 1);

    // replace-top and push+pop on empty
    cyc(1, 0, 8'h11, 0);
    cyc(1, 0, 8'h22, 0);
    cyc(1, 1, 8'h99, 0);
    cyc(0, 1, 8'h00, 0);
    cyc(0, 1, 8'h00, 0);
    cyc(1, 1, 8'h7E, 0);
    cyc(0, 1, 8'h00, 0);

    // set wins over err_clr
    cyc(0, 1, 8'h00, 1);
    for (int i = 0; i < 5; i++) cyc(1, 0, pat[i], 0);
    cyc(1, 1, 8'hA5, 0);
    cyc(1, 0, 8'hEE, 1);
    cyc(0, 0, 8'h00, 1);

    reset_pulse();
    cyc(1, 0, 8'h01, 0);
    cyc(1, 0, 8'h02, 0);
    cyc(1, 0, 8'h03, 0);
    cyc(0, 1, 8'h00, 0);
    cyc(0, 1, 8'h00, 0);
    cyc(1, 0, 8'h04, 0);
    idle_drain();
    check_state("hwm_seq");

    // reset held across an edge during a push burst
    cyc(1, 0, 8'hC1, 0);
    idle_drain();
    @(negedge clk);
    bus.push_en   = 1;
    bus.push_data = 8'hAA;
    clr_n = 0;
    model_reset();
    #1;
    check_state("rst_mid");
    @(posedge clk);
    #1;
    check_state("rst_edge");
    @(negedge clk);
    bus.push_en = 0;
    clr_n = 1;
    #1;
    check_state("rst_rel");

    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          8'($urandom), $urandom_range(0, 7) == 0);
    end
    idle_drain();
    check_state("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/param_stack.md
Name: param_stack

Overview:
- Parametrised LIFO stack; next generation of the team's 8-bit pointer stack.
- Arbitrary width and any depth ≥2, not only powers of two.
- Separate push/pop strobes, with simultaneous push+pop performing a replace-top.
- Provides an occupancy count, sticky overflow/underflow error flags and a zero-latency top-of-stack view; used by the processor for call/return and operand stacking.

Parameters:
WIDTH, 8, data word width in bits (≥1)
DEPTH, 16, number of entries (≥2, any integer)
- Derived localparam CW = $clog2(DEPTH+1), the width of the count port.

Ports:
clk  input  1  system clock; all state changes on posedge
clr_n  input  1  asynchronous, active-low reset
push_en  input  1  push request this cycle
pop_en  input  1  pop request this cycle
push_data  input  WIDTH  word to push
err_clr  input  1  clears sticky overflow/underflow flags
top  output  WIDTH  current top-of-stack word (value a pop would remove)
count  output  CW  number of valid entries, 0..DEPTH
full  output  1  1 when count == DEPTH
empty  output  1  1 when count == 0
overflow  output  1  sticky; push attempted while full (without pop)
underflow  output  1  sticky; pop attempted while empty (without push)
hwm  output  CW  high-water mark (present only with STACK_HWM_EN)

Behaviour:
Reset:
- clk is the single clock; clr_n is asynchronous, active-low.
- While clr_n=0: count=0, overflow=0, underflow=0, hwm=0.
- Consequently empty=1, full=0, top=0.
- Storage array is not cleared; entries at index ≥ count are don't-care.
- Asserting clr_n mid-operation aborts any in-flight request. The first posedge after release is a normal cycle.

Storage and outputs:
- Storage mem[0..DEPTH-1] with count as the stack pointer; next free slot = mem[count].
- top = mem[count-1] when count>0, else all zeros.
- top is a combinational read of registered state, valid immediately after the edge that updated it (zero-latency peek).
- full and empty decode count combinationally; no extra state.

Per-posedge actions (P=push_en, Q=pop_en):
- P=0,Q=0: hold.
- P=1,Q=0, not full: mem[count]<=push_data; count<=count+1.
- P=1,Q=0, full: data dropped; count holds; overflow<=1.
- P=0,Q=1, not empty: count<=count-1. Popped word is top in the cycle before the edge.
- P=0,Q=1, empty: count holds; underflow<=1.
- P=1,Q=1, not empty (including full): replace-top, mem[count-1]<=push_data; count unchanged; no error.
- P=1,Q=1, empty: acts as a plain push (count 0→1); no underflow.

Error flags:
- err_clr=1 clears both flags at the edge.
- If a new error occurs in the same cycle as err_clr, the set wins (flag = 1).

Arithmetic and boundaries:
- count never wraps: it saturates at 0 and DEPTH by the rules above.
- Width rule: count compares against DEPTH at CW bits, so non-power-of-two DEPTH (e.g. 5) behaves correctly.

Optional Feature:
STACK_HWM_EN
- Defined: hwm port and register exist.
- hwm<=max(hwm, next count) every cycle, so it holds the peak occupancy since reset.
- err_clr also resets hwm to the current count.
- Undefined: hwm port and logic are absent; all other behaviour is identical.

Test Plan:
1. Reset (WIDTH=8, DEPTH=4): pulse clr_n low between edges → count=0, empty=1, full=0, top=0x00, both flags 0, immediately (asynchronously).
2. Push 0x11,0x22,0x33,0x44 → count 1..4, top tracks each word, full=1 after 4th. 5th push 0x55 → count=4, top=0x44, overflow=1. err_clr → overflow=0.
3. From full: pop ×4 → top 0x44,0x33,0x22,0x11 sampled before each edge, count 4→0, empty=1. Extra pop → underflow=1, count=0.
4. Stack holds 0x11,0x22: push+pop with 0x99 → count=2, top=0x99. Then pop → top=0x11. Push+pop on empty with 0x7E → count=1, top=0x7E, no underflow.
5. DEPTH=5: 6 pushes → full at count=5, overflow on the 6th. Same cycle pop-on-empty with err_clr=1 → underflow=1 (set wins).
6. STACK_HWM_EN defined: push 3, pop 2, push 1 → hwm=3. Assert clr_n=0 mid-push burst → count=0, hwm=0, no write committed.
